// File: rtl/lcd_timing_pkg.sv
// Shared LCD line/field timing constants, saturation limits and receiver FSM states.
// Defaults describe a 1716-tick line with a 960x240 active window per field.
package lcd_timing_pkg;

   localparam int H_TOTAL    = 1716;
   localparam int H_DE_START = 70;
   localparam int H_DE_END   = 1029;
   localparam int V_DE_START = 21;
   localparam int V_DE_END   = 260;

   localparam logic [10:0] H_CNT_MAX = 11'd2047;
   localparam logic [9:0]  V_CNT_MAX = 10'd1023;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_HOLD    = 2'd3
   } lcd_state_t;

   // Inclusive window test shared by the horizontal and vertical DE decode.
   function automatic logic in_window(input logic [10:0] val,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer into the sys_clk domain, cleared by async rst.
module sync_2ff (
   input  logic sys_clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/lcd_sync_rx.sv
// LCD sync receiver: recovers pixel ticks from an async pixel clock, counts h/v position,
// classifies line lengths and tracks timing lock with a SEARCH/ACQUIRE/LOCKED/HOLD FSM.
module lcd_sync_rx #(
   parameter int H_TOTAL    = lcd_timing_pkg::H_TOTAL,
   parameter int H_TOL      = 2,
   parameter int LOCK_LINES = 8,
   parameter int H_DE_START = lcd_timing_pkg::H_DE_START,
   parameter int H_DE_END   = lcd_timing_pkg::H_DE_END,
   parameter int V_DE_START = lcd_timing_pkg::V_DE_START,
   parameter int V_DE_END   = lcd_timing_pkg::V_DE_END
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        clkin_in,
   input  logic        h_sync_in,
   input  logic        v_sync_in,
   output logic [10:0] h_cnt,
   output logic [9:0]  v_cnt,
   output logic        field,
   output logic        de,
   output logic        locked,
   output logic [10:0] line_len,
   output logic        line_err,
   output logic        field_start,
   output logic [1:0]  state_dbg
);

   import lcd_timing_pkg::*;

   localparam logic [1:0]  S_SEARCH  = ST_SEARCH;
   localparam logic [1:0]  S_ACQUIRE = ST_ACQUIRE;
   localparam logic [1:0]  S_LOCKED  = ST_LOCKED;
   localparam logic [1:0]  S_HOLD    = ST_HOLD;

   localparam logic [10:0] LEN_MIN  = 11'(H_TOTAL - H_TOL);
   localparam logic [10:0] LEN_MAX  = 11'(H_TOTAL + H_TOL);
   localparam logic [10:0] H_HALF   = 11'(H_TOTAL / 2);
   localparam logic [10:0] HDE_LO   = 11'(H_DE_START);
   localparam logic [10:0] HDE_HI   = 11'(H_DE_END);
   localparam logic [10:0] VDE_LO   = 11'(V_DE_START);
   localparam logic [10:0] VDE_HI   = 11'(V_DE_END);
   localparam logic [7:0]  LOCK_N   = 8'(LOCK_LINES);

   logic       clk_s, hs_s, vs_s;
   logic       clk_d, hs_prev, vs_prev;
   logic       pix_tick, h_fall, v_fall;
   logic [10:0] len_sat;
   logic       len_ok, line_good, line_bad;
   logic [1:0] state, state_n;
   logic [7:0] good_cnt, good_n;
   logic       v_seen, v_seen_n;

   sync_2ff u_sync_clk (.sys_clk(sys_clk), .rst(rst), .d(clkin_in),  .q(clk_s));
   sync_2ff u_sync_hs  (.sys_clk(sys_clk), .rst(rst), .d(h_sync_in), .q(hs_s));
   sync_2ff u_sync_vs  (.sys_clk(sys_clk), .rst(rst), .d(v_sync_in), .q(vs_s));

   // Syncs are only meaningful on pixel ticks, so falls compare successive tick samples.
   assign pix_tick = clk_s & ~clk_d;
   assign h_fall   = pix_tick & hs_prev & ~hs_s;
   assign v_fall   = pix_tick & vs_prev & ~vs_s;

   assign len_sat   = (h_cnt == H_CNT_MAX) ? H_CNT_MAX : h_cnt + 11'd1;
   assign len_ok    = (len_sat >= LEN_MIN) && (len_sat <= LEN_MAX);
   assign line_good = h_fall & len_ok;
   // Timeout fires on the tick that takes h_cnt to its ceiling; it cannot recur until an H fall.
   assign line_bad  = (h_fall & ~len_ok) |
                      (pix_tick & ~h_fall & (h_cnt == H_CNT_MAX - 11'd1));

   assign locked    = (state == S_LOCKED) || (state == S_HOLD);
   assign state_dbg = state;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         clk_d       <= 1'b0;
         hs_prev     <= 1'b0;
         vs_prev     <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         line_len    <= '0;
         field       <= 1'b0;
         field_start <= 1'b0;
      end else begin
         clk_d       <= clk_s;
         field_start <= 1'b0;
         if (pix_tick) begin
            hs_prev <= hs_s;
            vs_prev <= vs_s;
            if (h_fall) begin
               line_len <= len_sat;
               h_cnt    <= '0;
               if (v_cnt != V_CNT_MAX) begin
                  v_cnt <= v_cnt + 10'd1;
               end
            end else if (h_cnt != H_CNT_MAX) begin
               h_cnt <= h_cnt + 11'd1;
            end
            // V fall wins over the line increment; field parity comes from where in the line it landed.
            if (v_fall) begin
               v_cnt       <= '0;
               field_start <= 1'b1;
               field       <= ~(h_fall || (h_cnt < H_HALF));
            end
         end
      end
   end

   always_comb begin
      state_n  = state;
      good_n   = good_cnt;
      v_seen_n = v_seen | v_fall;
      case (state)
         S_SEARCH: begin
            good_n   = '0;
            v_seen_n = v_fall;
            if (h_fall) begin
               state_n = S_ACQUIRE;
            end
         end
         S_ACQUIRE: begin
            if (line_bad) begin
               state_n = S_SEARCH;
            end else begin
               if (line_good && (good_cnt != LOCK_N)) begin
                  good_n = good_cnt + 8'd1;
               end
               if ((good_cnt == LOCK_N) && v_seen) begin
                  state_n = S_LOCKED;
               end
            end
         end
         S_LOCKED: begin
            if (line_bad) begin
               state_n = S_HOLD;
            end
         end
         S_HOLD: begin
            if (line_bad) begin
               state_n = S_SEARCH;
            end else if (line_good) begin
               state_n = S_LOCKED;
            end
         end
         default: state_n = S_SEARCH;
      endcase
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state    <= S_SEARCH;
         good_cnt <= '0;
         v_seen   <= 1'b0;
         line_err <= 1'b0;
         de       <= 1'b0;
      end else begin
         state    <= state_n;
         good_cnt <= good_n;
         v_seen   <= v_seen_n;
         line_err <= line_bad && (state != S_SEARCH);
         de       <= locked &&
                     in_window(h_cnt, HDE_LO, HDE_HI) &&
                     in_window({1'b0, v_cnt}, VDE_LO, VDE_HI);
      end
   end

endmodule

// File: tb/tb_lcd_sync_rx.sv
// Directed bench for lcd_sync_rx using a short 32-tick line and the full 262.5-line field.
module tb_lcd_sync_rx;

   localparam int HT = 32;

   logic        sys_clk   = 1'b0;
   logic        rst       = 1'b1;
   logic        clkin_in  = 1'b0;
   logic        h_sync_in = 1'b1;
   logic        v_sync_in = 1'b1;
   logic [10:0] h_cnt;
   logic [9:0]  v_cnt;
   logic        field;
   logic        de;
   logic        locked;
   logic [10:0] line_len;
   logic        line_err;
   logic        field_start;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   int err_total = 0;
   int fs_total  = 0;
   int de_total  = 0;
   int de_mis    = 0;
   int v_peak    = 0;
   int de_snap   = 0;
   logic [10:0] h_prev  = '0;
   logic [9:0]  v_prev  = '0;
   logic        lk_prev = 1'b0;
   logic        rst_prev = 1'b1;

   lcd_sync_rx #(
      .H_TOTAL(HT), .H_TOL(2), .LOCK_LINES(8),
      .H_DE_START(4), .H_DE_END(23), .V_DE_START(21), .V_DE_END(260)
   ) dut (
      .sys_clk(sys_clk), .rst(rst), .clkin_in(clkin_in),
      .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
      .h_cnt(h_cnt), .v_cnt(v_cnt), .field(field), .de(de), .locked(locked),
      .line_len(line_len), .line_err(line_err), .field_start(field_start),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 sys_clk = ~sys_clk;

   initial begin
      #2;
      forever #10 clkin_in = ~clkin_in;
   end

   // ---------------- output monitor (scoreboard counters) ----------------
   always @(negedge sys_clk) begin
      if (line_err === 1'b1) err_total++;
      if (field_start === 1'b1) begin
         fs_total++;
         v_peak = int'(v_prev);
      end
      if (de === 1'b1) de_total++;
      if (!rst && !rst_prev &&
          (de !== (lk_prev && h_prev >= 11'd4 && h_prev <= 11'd23 &&
                   v_prev >= 10'd21 && v_prev <= 10'd260)))
         de_mis++;
      h_prev   = h_cnt;
      v_prev   = v_cnt;
      lk_prev  = locked;
      rst_prev = rst;
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input logic hs, input logic vs);
      @(negedge clkin_in);
      h_sync_in = hs;
      v_sync_in = vs;
   endtask

   task automatic send_line(input int len, input int vpos);
      for (int t = 0; t < len; t++)
         tick(!(t < 4), !((vpos >= 0) && (t >= vpos) && (t < vpos + 3)));
   endtask

   task automatic idle(input int n);
      for (int t = 0; t < n; t++) tick(1'b1, 1'b1);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      repeat (3) @(negedge sys_clk);
      check("rst_h_cnt", 32'(h_cnt), 0);
      check("rst_v_cnt", 32'(v_cnt), 0);
      check("rst_field", 32'(field), 0);
      check("rst_de", 32'(de), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_line_len", 32'(line_len), 0);
      check("rst_line_err", 32'(line_err), 0);
      check("rst_field_start", 32'(field_start), 0);
      check("rst_state", 32'(state_dbg), 0);

      @(negedge clkin_in);
      rst = 1'b0;
      idle(4);

      // Field A: V fall with the first H fall, second V fall mid-line 262.
      for (int ln = 0; ln < 263; ln++) begin
         send_line(HT, (ln == 0) ? 0 : ((ln == 262) ? 17 : -1));
         if (ln == 0) check("acquire_entry", 32'(state_dbg), 1);
         if (ln == 7) check("not_locked_7_lines", 32'(locked), 0);
         if (ln == 8) check("locked_8_lines", 32'(locked), 1);
      end
      check("fieldA_v_peak", 32'(v_peak), 262);
      check("fieldA_field_odd_to_even", 32'(field), 1);
      check("fieldA_fs_count", 32'(fs_total), 2);
      check("ideal_line_len", 32'(line_len), HT);
      check("ideal_no_err", 32'(err_total), 0);
      de_snap = de_total;

      // Field B: full locked field, ends with V fall coincident with H fall.
      for (int ln = 263; ln < 525; ln++) send_line(HT, -1);
      check("fieldB_de_cycles", 32'(de_total - de_snap), 240 * 20 * 2);
      check("fieldB_field_held", 32'(field), 1);
      send_line(HT, 0);
      check("fieldB_v_peak", 32'(v_peak), 262);
      check("fieldB_field_even_to_odd", 32'(field), 0);
      check("fieldB_fs_count", 32'(fs_total), 3);
      check("fieldB_no_err", 32'(err_total), 0);

      // Tolerance edges: +2 and -2 are good lines.
      send_line(34, -1);
      send_line(30, -1);
      send_line(HT, -1);
      check("tol_edges_no_err", 32'(err_total), 0);
      check("tol_edges_locked_state", 32'(state_dbg), 2);
      check("tol_edges_line_len", 32'(line_len), 30);

      // One short line while locked -> HOLD, then recover.
      send_line(26, -1);
      send_line(HT, -1);
      check("short_line_err", 32'(err_total), 1);
      check("short_line_hold", 32'(state_dbg), 3);
      check("short_line_still_locked", 32'(locked), 1);
      check("short_line_len", 32'(line_len), 26);
      send_line(HT, -1);
      check("hold_to_locked", 32'(state_dbg), 2);

      // Two consecutive bad lines (+3 then -3) -> SEARCH.
      send_line(35, -1);
      send_line(29, -1);
      send_line(HT, -1);
      check("two_bad_err", 32'(err_total), 3);
      check("two_bad_unlocked", 32'(locked), 0);
      check("two_bad_search", 32'(state_dbg), 0);

      // Reacquire: eight good lines are not enough without a V fall.
      for (int i = 0; i < 9; i++) send_line(HT, -1);
      check("reacq_no_vfall_unlocked", 32'(locked), 0);
      check("reacq_no_vfall_state", 32'(state_dbg), 1);
      send_line(HT, 17);
      check("reacq_vfall_locked", 32'(locked), 1);
      check("reacq_field_even", 32'(field), 1);
      check("reacq_no_err", 32'(err_total), 3);

      // H sync stuck high: one timeout error, then the long line drops lock.
      idle(2060);
      check("timeout_err_once", 32'(err_total), 4);
      check("timeout_hold", 32'(state_dbg), 3);
      check("timeout_h_sat", 32'(h_cnt), 2047);
      send_line(HT, -1);
      check("timeout_line_err", 32'(err_total), 5);
      check("timeout_unlocked", 32'(locked), 0);
      check("timeout_search", 32'(state_dbg), 0);
      check("timeout_line_len", 32'(line_len), 2047);

      // Lock again, then reset mid-line.
      for (int i = 0; i < 9; i++) send_line(HT, -1);
      send_line(HT, 17);
      send_line(HT, -1);
      send_line(HT, -1);
      send_line(12, -1);
      check("pre_rst_locked", 32'(locked), 1);
      check("pre_rst_v_cnt", 32'(v_cnt), 3);
      rst = 1'b1;
      #1;
      check("midrst_h_cnt", 32'(h_cnt), 0);
      check("midrst_v_cnt", 32'(v_cnt), 0);
      check("midrst_field", 32'(field), 0);
      check("midrst_locked", 32'(locked), 0);
      check("midrst_line_len", 32'(line_len), 0);
      check("midrst_de", 32'(de), 0);
      check("midrst_state", 32'(state_dbg), 0);
      repeat (4) @(negedge clkin_in);
      rst = 1'b0;
      idle(4);
      send_line(HT, 0);
      for (int i = 0; i < 7; i++) send_line(HT, -1);
      check("post_rst_7_lines_unlocked", 32'(locked), 0);
      send_line(HT, -1);
      check("post_rst_8_lines_locked", 32'(locked), 1);
      check("post_rst_no_err", 32'(err_total), 5);

      check("de_window_exact", 32'(de_mis), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lcd_sync_rx.md
LCD_SYNC_RX -- requirements
Module: lcd_sync_rx

Interface
REQ-001 SHALL have parameter H_TOTAL, default 1716, nominal sys_clk/2 pixel ticks per line.
REQ-002 SHALL have parameter H_TOL, default 2, allowed ± deviation of measured line length.
REQ-003 SHALL have parameter LOCK_LINES, default 8, consecutive good lines required to lock.
REQ-004 SHALL have parameters H_DE_START=70, H_DE_END=1029, V_DE_START=21 and V_DE_END=260, all inclusive active-window bounds.
REQ-005 SHALL have port sys_clk, input, 1, system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port clkin_in, input, 1, incoming LCD pixel clock, asynchronous to sys_clk.
REQ-008 SHALL have ports h_sync_in and v_sync_in, input, 1 each, active-low sync pulses, asynchronous.
REQ-009 SHALL have port h_cnt, output, 11, pixel tick index within the line.
REQ-010 SHALL have port v_cnt, output, 10, line index within the field.
REQ-011 SHALL have port field, output, 1: 0 = first/odd field, 1 = second/even field.
REQ-012 SHALL have port de, output, 1, active-window data enable.
REQ-013 SHALL have port locked, output, 1, timing lock indicator.
REQ-014 SHALL have port line_len, output, 11, last measured line length.
REQ-015 SHALL have ports line_err and field_start, output, 1 each, single-cycle pulses.

Function
REQ-016 SHALL pass each async input through its own 2-flop synchronizer; pix tick = synchronized clkin_in 0->1 edge, one sys_clk wide.
REQ-017 SHALL sample synchronized syncs only on pix ticks; H fall = high on previous tick, low on current tick; V fall likewise.
REQ-018 On a pix tick with H fall: line_len <= min(h_cnt+1, 2047); h_cnt <= 0; v_cnt <= min(v_cnt+1, 1023); all updated the cycle after the tick.
REQ-019 On a pix tick without H fall: h_cnt SHALL increment, saturating at 2047.
REQ-020 On V fall: v_cnt <= 0 (overrides the REQ-018 increment); field_start pulses for one cycle.
REQ-021 On V fall, field <= 0 if an H fall occurs on the same tick or pre-tick h_cnt < H_TOTAL/2; otherwise field <= 1.
REQ-022 A line SHALL be good iff an H fall occurs with h_cnt+1 within H_TOTAL±H_TOL; it SHALL be bad on an out-of-range H fall, or when h_cnt reaches 2047 (timeout, flagged once until the next H fall).
REQ-023 line_err SHALL pulse for one cycle per bad line, in any state except SEARCH.
REQ-024 FSM SEARCH SHALL go to ACQUIRE on the first H fall, with the good-line counter cleared.
REQ-025 FSM ACQUIRE SHALL increment on each good line; on a bad line it SHALL go to SEARCH; when it reaches LOCK_LINES and at least one V fall has been seen since SEARCH, it SHALL go to LOCKED.
REQ-026 FSM LOCKED SHALL go to HOLD on a bad line.
REQ-027 FSM HOLD SHALL return to LOCKED on a good line and go to SEARCH on a bad line.
REQ-028 locked SHALL be 1 in LOCKED and HOLD, and 0 otherwise.
REQ-029 de SHALL be registered and equal locked AND h_cnt in [H_DE_START, H_DE_END] AND v_cnt in [V_DE_START, V_DE_END].
REQ-030 Pixel-to-output latency SHALL be fixed: 2 sync flops + 1 edge flop + 1 output register.

Reset
REQ-031 rst SHALL asynchronously clear h_cnt, v_cnt, field, de, locked, line_len, line_err, field_start, the synchronizers and the good-line counter, and SHALL force SEARCH.
REQ-032 Reset asserted mid-line or mid-field SHALL take effect immediately; after release, lock SHALL require a full reacquire per REQ-025.

Structure
REQ-033 Package lcd_timing_pkg SHALL hold H_TOTAL, all DE bounds, the 2047/1023 saturation limits and the FSM state enum (SEARCH, ACQUIRE, LOCKED, HOLD).
REQ-034 The only sub-module SHALL be sync_2ff (single-bit 2-flop synchronizer), instantiated three times.

Verification
REQ-035 Drive ideal timing (1716-tick lines, V period 450450 ticks) -> locked=1 after 8 lines plus one V fall; line_err never pulses; line_len=1716.
REQ-036 Alternating V falls at h_cnt=0 and at h_cnt=858 -> field toggles 0/1; field_start pulses once per field; v_cnt reaches 262 before clearing.
REQ-037 While locked, shorten one line to 1710 ticks -> line_err pulse, state HOLD, locked stays 1; next good line -> LOCKED.
REQ-038 Two consecutive bad lines, or H_SYNC held high for 2047 ticks -> line_err, locked=0, state SEARCH.
REQ-039 Count de-high cycles across one locked field -> exactly 960 pix ticks per line on lines 21..260, zero elsewhere.
REQ-040 Assert rst mid-field -> all outputs 0 immediately; after release, locked stays 0 for at least 8 lines.
